// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the lsu_ext load-store unit.
//   size_e   : access size encodings (byte/half/word/dword)
//   state_e  : control FSM states
//   beat_bytes / off_bits : constants derived from the memory data width
//   misaligned : alignment check of a byte address for a given size
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int BYTE_W = 8;

  // Bytes carried by one memory beat.
  function automatic int beat_bytes(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Width of the byte offset within one beat.
  function automatic int off_bits(input int data_w);
    return $clog2(data_w / BYTE_W);
  endfunction

  // An access is misaligned when addr mod 2^size != 0.
  function automatic logic misaligned(input size_e size, input logic [2:0] low);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return low[0];
      SZ_W:    return |low[1:0];
      default: return |low[2:0];
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- combinational lane logic for lsu_ext.
//   off           in  byte offset of the access within the beat
//   size          in  access size
//   load_unsigned in  1 = zero-extend loads, 0 = sign-extend
//   wdata         in  right-aligned store data
//   rdata         in  raw read beat from memory
//   wmask         out byte-enable mask placed on the addressed lanes
//   wdata_sh      out store data shifted onto the addressed lanes
//   rdata_ext     out load field extracted and extended to DATA_W
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int BYTES = beat_bytes(DATA_W),
  localparam int OFF_W = off_bits(DATA_W)
) (
  input  logic [OFF_W-1:0]  off,
  input  size_e             size,
  input  logic              load_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BYTES-1:0]  wmask,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [BYTES-1:0]  size_mask;  // 2^size low bytes set
  logic [DATA_W-1:0] keep_mask;  // size_mask expanded to bits
  logic [DATA_W-1:0] rdata_sh;
  logic              sign_bit;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign size_mask[gi] = (32'(gi) < (32'd1 << size));
      assign keep_mask[gi*8 +: 8] = {8{size_mask[gi]}};
    end
  endgenerate

  assign wmask    = size_mask << off;
  assign wdata_sh = wdata << {off, 3'b000};
  assign rdata_sh = rdata >> {off, 3'b000};

  // Extension fills every bit above the field with the field's top bit
  // (or zero), so one mask handles all sizes.
  always_comb begin
    sign_bit = 1'b0;
    case (size)
      SZ_B:    sign_bit = rdata_sh[7];
      SZ_H:    sign_bit = rdata_sh[15];
      SZ_W:    sign_bit = rdata_sh[31];
      default: sign_bit = rdata_sh[DATA_W-1];
    endcase
    rdata_ext = (rdata_sh & keep_mask) |
                ({DATA_W{sign_bit & ~load_unsigned}} & ~keep_mask);
  end

endmodule

// File: rtl/lsu_ext.sv
// lsu_ext -- load-store unit between execute stage and a valid/ready memory port.
// One access outstanding; loads and stores both wait for a memory response.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        access handshake from EXU (ready only in IDLE)
//   in_wen/addr/wdata/size/unsigned  access fields, latched on accept
//   out_valid/rdata/err      one-cycle completion pulse to WBU, data/err held
//   mem_req_valid/ready      memory request handshake
//   mem_addr/wen/wdata/wmask beat-aligned request fields (0 outside REQ)
//   mem_resp_valid/rdata/resp_err  memory response
// Optional: define LSU_TIMEOUT_EN to enable a watchdog that ends an access
// with an error after TIMEOUT_CYC cycles in REQ/WAIT.
module lsu_ext
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  localparam int BYTES = beat_bytes(DATA_W),
  localparam int OFF_W = off_bits(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BYTES-1:0]  mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp_err
);

  state_e            state_reg, state_next;
  logic              wen_reg, wen_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  size_e             size_reg, size_next;
  logic              unsigned_reg, unsigned_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;

  logic              req_active;
  logic              bad_access;
  logic              timeout_hit;
  logic [BYTES-1:0]  lane_wmask;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] load_ext;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .off           (addr_reg[OFF_W-1:0]),
    .size          (size_reg),
    .load_unsigned (unsigned_reg),
    .wdata         (wdata_reg),
    .rdata         (mem_rdata),
    .wmask         (lane_wmask),
    .wdata_sh      (lane_wdata),
    .rdata_ext     (load_ext)
  );

  // Dword accesses cannot be served by a 32-bit port.
  assign bad_access = misaligned(size_e'(in_size), in_addr[2:0]) ||
                      ((size_e'(in_size) == SZ_D) && (DATA_W == 32));

`ifdef LSU_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] timer_reg;

  // Held at zero outside REQ/WAIT, so it is clear on every entry to REQ.
  always_ff @(posedge clk) begin
    if (rst || state_reg == ST_IDLE || state_reg == ST_DONE) begin
      timer_reg <= '0;
    end else if (!timeout_hit) begin
      timer_reg <= timer_reg + TMR_W'(1);
    end
  end

  assign timeout_hit = ((state_reg == ST_REQ) || (state_reg == ST_WAIT)) &&
                       (timer_reg == TMR_W'(TIMEOUT_CYC));
`else
  logic [31:0] timeout_cfg_unused;
  assign timeout_cfg_unused = 32'(TIMEOUT_CYC);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wen_reg      <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      size_reg     <= SZ_B;
      unsigned_reg <= 1'b0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wen_reg      <= wen_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      size_reg     <= size_next;
      unsigned_reg <= unsigned_next;
      rdata_reg    <= rdata_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wen_next      = wen_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    size_next     = size_reg;
    unsigned_next = unsigned_reg;
    rdata_next    = rdata_reg;
    err_next      = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          wen_next      = in_wen;
          addr_next     = in_addr;
          wdata_next    = in_wdata;
          size_next     = size_e'(in_size);
          unsigned_next = in_unsigned;
          if (bad_access) begin
            rdata_next = '0;
            err_next   = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (timeout_hit) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = ST_DONE;
        end else if (mem_req_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (timeout_hit) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = ST_DONE;
        end else if (mem_resp_valid) begin
          rdata_next = (wen_reg || mem_resp_err) ? '0 : load_ext;
          err_next   = mem_resp_err;
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign req_active    = (state_reg == ST_REQ);
  assign in_ready      = (state_reg == ST_IDLE);
  assign out_valid     = (state_reg == ST_DONE);
  assign out_rdata     = rdata_reg;
  assign out_err       = err_reg;
  assign mem_req_valid = req_active;
  assign mem_addr      = req_active ? {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_wen       = req_active & wen_reg;
  assign mem_wdata     = req_active ? lane_wdata : '0;
  assign mem_wmask     = req_active ? lane_wmask : '0;

endmodule

// File: tb/tb_lsu_ext.sv
module tb_lsu_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  int vectors = 0;
  int miscompares = 0;
  int lat;

  always #5 clk = ~clk;

  lsu_ext #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_wen        (in_wen),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_size       (in_size),
    .in_unsigned   (in_unsigned),
    .out_valid     (out_valid),
    .out_rdata     (out_rdata),
    .out_err       (out_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata),
    .mem_resp_err  (mem_resp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
  endtask

  // Present one access with memory ready/response always asserted and
  // wait (bounded) for out_valid; lat = cycles from accept edge.
  task automatic run_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic uns,
                            input logic [31:0] rdata, input logic rerr, output int cyc);
    mem_resp_valid = 1'b0;
    if (!in_ready) tick();
    in_valid = 1'b1; in_wen = wen; in_addr = addr; in_wdata = wdata;
    in_size = size; in_unsigned = uns;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = rdata; mem_resp_err = rerr;
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_addr = '0; in_wdata = '0;
    in_size = 2'd0; in_unsigned = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_rdata = '0; mem_resp_err = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_out_rdata", out_rdata, 0);
    check("rst_out_err", out_err, 0);
    check("rst_wmask", mem_wmask, 0);
    rst = 1'b0;
    tick();

    // Aligned word load, ready/response immediate (response also present in REQ).
    in_valid = 1'b1; in_wen = 1'b0; in_addr = 32'h8000_0004; in_size = 2'd2; in_unsigned = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_resp_err = 1'b0;
    tick();
    in_valid = 1'b0;
    check("lw_n1_req_valid", mem_req_valid, 1);
    check("lw_n1_addr", mem_addr, 32'h8000_0004);
    check("lw_n1_in_ready", in_ready, 0);
    check("lw_n1_out_valid", out_valid, 0);
    tick();
    check("lw_n2_req_valid", mem_req_valid, 0);
    check("lw_n2_out_valid", out_valid, 0);
    tick();
    check("lw_n3_out_valid", out_valid, 1);
    check("lw_n3_rdata", out_rdata, 32'hDEAD_BEEF);
    check("lw_n3_err", out_err, 0);
    mem_resp_valid = 1'b0;
    tick();
    check("lw_pulse_end", out_valid, 0);
    check("lw_hold_rdata", out_rdata, 32'hDEAD_BEEF);
    check("lw_in_ready", in_ready, 1);

    // Byte loads at offset 3: signed and unsigned; half load at offset 2.
    run_access(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'h80FF_0000, 1'b0, lat);
    check("lb_lat", lat, 3);
    check("lb_rdata", out_rdata, 32'hFFFF_FF80);
    run_access(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 32'h80FF_0000, 1'b0, lat);
    check("lbu_rdata", out_rdata, 32'h0000_0080);
    run_access(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 32'h80FF_0000, 1'b0, lat);
    check("lh_rdata", out_rdata, 32'hFFFF_80FF);
    run_access(1'b0, 32'h8000_0001, 32'h0, 2'd0, 1'b0, 32'h1234_5678, 1'b0, lat);
    check("lb1_rdata", out_rdata, 32'h0000_0056);
    run_access(1'b0, 32'h8000_0000, 32'h0, 2'd1, 1'b1, 32'h1234_F678, 1'b0, lat);
    check("lhu0_rdata", out_rdata, 32'h0000_F678);

    // Bus error on a load: error flagged, data zeroed.
    run_access(1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b1, lat);
    check("berr_err", out_err, 1);
    check("berr_rdata", out_rdata, 0);
    run_access(1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 32'h0BAD_CAFE, 1'b0, lat);
    check("ok_after_berr_err", out_err, 0);
    check("ok_after_berr_rdata", out_rdata, 32'h0BAD_CAFE);

    // Half store at offset 2 with ready stalled for 5 cycles.
    mem_resp_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_wen = 1'b1; in_addr = 32'h8000_0002; in_wdata = 32'h0000_1234;
    in_size = 2'd1; in_unsigned = 1'b0; mem_req_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_wdata = 32'hFFFF_FFFF; in_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("sh_wmask", mem_wmask, 4'b1100);
      check("sh_wdata", mem_wdata, 32'h1234_0000);
      check("sh_addr", mem_addr, 32'h8000_0000);
      check("sh_wen", mem_wen, 1);
      check("sh_req_valid", mem_req_valid, 1);
      check("sh_in_ready", in_ready, 0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("sh_wait_req_valid", mem_req_valid, 0);
    tick(); tick();
    check("sh_no_resp_out_valid", out_valid, 0);
    mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_resp_err = 1'b0;
    tick();
    mem_resp_valid = 1'b0;
    check("sh_done_valid", out_valid, 1);
    check("sh_done_rdata", out_rdata, 0);
    check("sh_done_err", out_err, 0);
    tick();

    // Misaligned word: completes at N+1 with error, no memory request.
    in_valid = 1'b1; in_wen = 1'b0; in_addr = 32'h8000_0001; in_size = 2'd2;
    mem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mis_w_out_valid", out_valid, 1);
    check("mis_w_err", out_err, 1);
    check("mis_w_req_valid", mem_req_valid, 0);
    check("mis_w_rdata", out_rdata, 0);
    tick();
    check("mis_w_idle", in_ready, 1);
    check("mis_w_req_valid2", mem_req_valid, 0);

    // Misaligned half, and dword on a 32-bit port.
    run_access(1'b0, 32'h8000_0003, 32'h0, 2'd1, 1'b0, 32'h1111_1111, 1'b0, lat);
    check("mis_h_lat", lat, 1);
    check("mis_h_err", out_err, 1);
    run_access(1'b1, 32'h8000_0000, 32'h5, 2'd3, 1'b0, 32'h1111_1111, 1'b0, lat);
    check("dword_lat", lat, 1);
    check("dword_err", out_err, 1);
    // Aligned word store at offset 0: full mask.
    mem_resp_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_wen = 1'b1; in_addr = 32'h8000_0010; in_wdata = 32'hA5A5_5A5A;
    in_size = 2'd2; mem_req_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("sw_wmask", mem_wmask, 4'b1111);
    check("sw_wdata", mem_wdata, 32'hA5A5_5A5A);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;

    // Reset while in WAIT, then a late response: ignored.
    rst = 1'b1;
    tick();
    check("rstw_in_ready", in_ready, 1);
    check("rstw_out_valid", out_valid, 0);
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    check("late_resp_out_valid", out_valid, 0);
    check("late_resp_in_ready", in_ready, 1);
    mem_resp_valid = 1'b0;
    tick();
    check("late_resp_out_valid2", out_valid, 0);
    check("late_resp_rdata", out_rdata, 0);

`ifdef LSU_TIMEOUT_EN
    // Request accepted, response never arrives: watchdog fires.
    in_valid = 1'b1; in_wen = 1'b0; in_addr = 32'h8000_0020; in_size = 2'd2;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("tmo_out_valid", out_valid, 1);
    check("tmo_err", out_err, 1);
    check("tmo_rdata", out_rdata, 0);
    tick();
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("tmo_stray_out_valid", out_valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_ext.md
Name: lsu_ext

Overview:
- Parametrised successor load-store unit: accepts one access per handshake from the execute stage and drives a valid/ready request, valid response memory port.
- Unlike the first-generation LSU, stores also wait for a memory response.
- Handles byte/half/word(/dword) sizes: lane shifting, write-mask generation, sign/zero extension of loads.
- Detects misaligned and illegal accesses; result returned to WBU as a one-cycle out_valid pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, memory/data width; legal values 32 or 64.
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  access request from EXU.
- in_ready  out  1  LSU can accept (IDLE only).
- in_wen  in  1  1=store, 0=load.
- in_addr  in  ADDR_W  byte address.
- in_wdata  in  DATA_W  store data, right-aligned.
- in_size  in  2  0=byte 1=half 2=word 3=dword.
- in_unsigned  in  1  1=zero-extend load, 0=sign-extend.
- out_valid  out  1  one-cycle completion pulse.
- out_rdata  out  DATA_W  extended load data; 0 for stores/errors.
- out_err  out  1  access faulted; valid with out_valid.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  in_addr with low log2(DATA_W/8) bits cleared.
- mem_wen  out  1  write request.
- mem_wdata  out  DATA_W  store data shifted to byte lane.
- mem_wmask  out  DATA_W/8  byte-enable mask, 1=write.
- mem_resp_valid  in  1  memory response.
- mem_rdata  in  DATA_W  raw read beat.
- mem_resp_err  in  1  bus error, sampled with mem_resp_valid.

Behaviour:
- Reset (sync, active-high): state=IDLE; in_ready=1 after reset; all other outputs 0. Reset mid-operation abandons the access; late mem_resp_valid is ignored in IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch all in_* fields.
  - If misaligned (addr mod 2^size != 0) or size=3 with DATA_W=32, go to DONE with err=1; no memory access.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1; mem_addr/wen/wdata/wmask held stable until mem_req_ready.
  - On ready, go to WAIT.
  - mem_resp_valid in REQ is ignored.
- WAIT:
  - On mem_resp_valid, register result (load data or 0) and err=mem_resp_err, then go to DONE.
- DONE:
  - out_valid=1 for exactly one cycle, then IDLE.
  - out_rdata/out_err hold their value until the next DONE.
- Latency: accept at cycle N; out_valid earliest at N+3 (ready in REQ, response in first WAIT cycle); misaligned access completes at N+1.
- Lane rules (off = addr low bits):
  - mem_wmask = ((1<<2^size)-1) << off.
  - mem_wdata = in_wdata << 8*off.
  - Load: byte field = mem_rdata >> 8*off, truncated to 8*2^size bits, then extended to DATA_W.
- Only one access outstanding; in_ready=0 in REQ/WAIT/DONE.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- When defined: counter cleared on entering REQ, increments in REQ and WAIT. When it reaches TIMEOUT_CYC, go to DONE with out_err=1, out_rdata=0; mem_req_valid drops; a subsequent stray response is ignored.
- When undefined: no counter; LSU waits indefinitely.

Decomposition:
- Shared package lsu_pkg: size encodings (SZ_B/SZ_H/SZ_W/SZ_D), state enum, DATA_W-derived constants (bytes per beat, offset width).
- One natural combinational sub-module lsu_align: mask/shift generation and load extraction/extension. Top holds FSM, latches and the watchdog.

Test Plan:
- Aligned word load 0x8000_0004, mem_rdata=0xDEAD_BEEF, ready/resp immediate -> out_valid at N+3, out_rdata=0xDEAD_BEEF, out_err=0.
- Byte load signed addr 0x8000_0003, mem_rdata=0x80FF_0000 -> out_rdata=0xFFFF_FF80; with in_unsigned=1 -> 0x0000_0080.
- Half store addr 0x8000_0002, in_wdata=0x1234 -> mem_wmask=4'b1100, mem_wdata=0x1234_0000, mem_addr=0x8000_0000; completes only after mem_resp_valid.
- Misaligned word load addr 0x8000_0001 -> mem_req_valid never asserted, out_valid at N+1, out_err=1.
- mem_req_ready held low 5 cycles -> request fields stable throughout; in_ready=0; completion follows ready and response.
- rst asserted in WAIT, then mem_resp_valid -> no out_valid; next cycle in_ready=1. With LSU_TIMEOUT_EN and TIMEOUT_CYC=8 and no response -> out_err=1 after 8 cycles.
